voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice allocator. Note-on/note-off events go to NUM_VOICES voice
// slots. Each slot drives one phase accumulator note_value. For each accepted
// event, the block scans every slot, one slot per cycle. It then applies a
// single update: retrigger, allocate, steal the oldest voice, or release.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-low reset
//   evt_valid_in      note event present
//   evt_ready_out     event accepted this cycle (high only in IDLE)
//   evt_on_in         1 = note-on, 0 = note-off
//   evt_note_in       note number of the event
//   voice_note_out    note of voice i in bits [i*NOTE_W +: NOTE_W]
//   voice_active_out  bit i high while voice i is sounding
//   voice_retrig_out  one-cycle pulse on (re)assignment of voice i
//   steal_out         one-cycle pulse when a note-on evicts an active voice
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         evt_valid_in,
  output logic                         evt_ready_out,
  input  logic                         evt_on_in,
  input  logic [NOTE_W-1:0]            evt_note_in,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out,
  output logic [NUM_VOICES-1:0]        voice_active_out,
  output logic [NUM_VOICES-1:0]        voice_retrig_out,
  output logic                         steal_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               on_q, on_d;
  logic [NOTE_W-1:0]                  note_q, note_d;
  logic                               match_vld_q, match_vld_d;
  logic [IDX_W-1:0]                   match_idx_q, match_idx_d;
  logic                               free_vld_q, free_vld_d;
  logic [IDX_W-1:0]                   free_idx_q, free_idx_d;
  logic                               old_vld_q, old_vld_d;
  logic [IDX_W-1:0]                   old_idx_q, old_idx_d;
  logic [7:0]                         old_age_q, old_age_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]  notes_q, notes_d;
  logic [NUM_VOICES-1:0]              active_q, active_d;
  logic [NUM_VOICES-1:0][7:0]         ages_q, ages_d;
  logic [NUM_VOICES-1:0]              retrig_q, retrig_d;
  logic                               steal_q, steal_d;
  logic [IDX_W-1:0]                   tgt_idx;

  // The packed array layout places voice i at [i*NOTE_W +: NOTE_W].
  assign voice_note_out   = notes_q;
  assign voice_active_out = active_q;
  assign voice_retrig_out = retrig_q;
  assign steal_out        = steal_q;
  assign evt_ready_out    = (state_q == IDLE);

  // Next-state logic: event latch, slot scan, and one-cycle apply.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    notes_d     = notes_q;
    active_d    = active_q;
    ages_d      = ages_q;
    retrig_d    = '0;
    steal_d     = 1'b0;
    tgt_idx     = '0;

    case (state_q)
      IDLE: begin
        if (evt_valid_in) begin
          on_d        = evt_on_in;
          note_d      = evt_note_in;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
          old_age_d   = 8'd0;
          state_d     = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        // Each "first hit" flag keeps the lowest index found so far.
        if (active_q[idx_q] && (notes_q[idx_q] == note_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end else begin
          match_vld_d = match_vld_q;
        end
        if (!active_q[idx_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end else begin
          free_vld_d = free_vld_q;
        end
        // The strict greater-than keeps the lowest index on equal ages.
        if (active_q[idx_q] && (!old_vld_q || (ages_q[idx_q] > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = ages_q[idx_q];
        end else begin
          old_vld_d = old_vld_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = APPLY;
        end else begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end

      APPLY: begin
        state_d = IDLE;
        if (on_q) begin
          // Priority: retrigger the matching voice, else use a free slot,
          // else steal. Stealing implies all slots are active, so the
          // oldest-voice record is always valid on that path.
          if (match_vld_q) begin
            tgt_idx = match_idx_q;
          end else if (free_vld_q) begin
            tgt_idx = free_idx_q;
          end else begin
            tgt_idx = old_idx_q;
          end
          steal_d = !match_vld_q && !free_vld_q;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt_idx) begin
              notes_d[i]  = note_q;
              active_d[i] = 1'b1;
              ages_d[i]   = 8'd0;
              retrig_d[i] = 1'b1;
            end else if (active_q[i] && (ages_q[i] != 8'hFF)) begin
              ages_d[i] = ages_q[i] + 8'd1;
            end else begin
              ages_d[i] = ages_q[i];
            end
          end
        end else if (match_vld_q) begin
          // A zero note field gives a zero phase increment to the released voice.
          notes_d[match_idx_q]  = {NOTE_W{1'b0}};
          active_d[match_idx_q] = 1'b0;
          ages_d[match_idx_q]   = 8'd0;
        end else begin
          notes_d = notes_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= 8'd0;
      notes_q     <= '0;
      active_q    <= '0;
      ages_q      <= '0;
      retrig_q    <= '0;
      steal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      notes_q     <= notes_d;
      active_q    <= active_d;
      ages_q      <= ages_d;
      retrig_q    <= retrig_d;
      steal_q     <= steal_d;
    end
  end

endmodule
